// File: rtl/board_reset_seq_pkg.sv
// Shared types for the board reset sequencer: reset cause codes, FSM states,
// and a counter-width helper.
package board_pkg;

  typedef enum logic [1:0] {
    CAUSE_POR    = 2'd0,
    CAUSE_LOCK   = 2'd1,
    CAUSE_BUTTON = 2'd2,
    CAUSE_SW     = 2'd3
  } reset_cause_t;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } rst_state_t;

  // Bits needed to count 0..terminal-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned terminal);
    return (terminal > 1) ? $clog2(terminal) : 1;
  endfunction

endpackage

// File: rtl/board_reset_seq_sync.sv
// Two-flop synchroniser with an optional stability filter. DEBOUNCE_CYCLES=0
// gives the bare synchroniser; otherwise the output follows the synchronised
// level only after it has differed for DEBOUNCE_CYCLES consecutive cycles.
module sync_debounce
  import board_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 0,
  parameter logic        INIT            = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level
);

  logic sync_1;
  logic sync_2;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_1 <= INIT;
      sync_2 <= INIT;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_sync_only
      assign level = sync_2;
    end else begin : g_debounce
      localparam int unsigned   CW   = cnt_width(DEBOUNCE_CYCLES);
      localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0] stable_cnt;
      logic          state;

      // Any cycle that agrees with the held state restarts the count.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          state      <= INIT;
          stable_cnt <= '0;
        end else if (sync_2 == state) begin
          stable_cnt <= '0;
        end else if (stable_cnt == LAST) begin
          state      <= sync_2;
          stable_cnt <= '0;
        end else begin
          stable_cnt <= stable_cnt + 1'b1;
        end
      end

      assign level = state;
    end
  endgenerate

endmodule

// File: rtl/board_reset_seq.sv
// Board reset sequencer: merges PLL locks, debounced buttons and a software
// request into one fault, holds all domains in reset, then releases them in order.
module board_reset_seq
  import board_pkg::*;
#(
  parameter int unsigned NUM_LOCKS       = 2,
  parameter int unsigned NUM_BTNS        = 1,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1,
  parameter int unsigned NUM_DOMAINS     = 3,
  parameter int unsigned HOLD_CYCLES     = 1024,
  parameter int unsigned STAGE_CYCLES    = 64,
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic                   clk,
  input  logic                   reset_n_i,
  input  logic [NUM_LOCKS-1:0]   locked_i,
  input  logic [NUM_BTNS-1:0]    btn_i,
  input  logic                   sw_reset_i,
  output logic [NUM_DOMAINS-1:0] reset_o,
  output logic                   ready_o,
  output reset_cause_t           cause_o,
  output rst_state_t             state_o
);

  localparam logic BTN_RELEASED = BTN_ACTIVE_LOW ? 1'b1 : 1'b0;

  localparam int unsigned   HW         = cnt_width(HOLD_CYCLES);
  localparam int unsigned   SW         = cnt_width(STAGE_CYCLES);
  localparam int unsigned   IW         = cnt_width(NUM_DOMAINS);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] STAGE_LAST = SW'(STAGE_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DOMAINS - 1);

  logic [NUM_LOCKS-1:0] lock_sync;
  logic [NUM_BTNS-1:0]  btn_level;
  logic [NUM_BTNS-1:0]  btn_pressed;
  logic                 lock_lost;
  logic                 btn_fault;
  logic                 fault;

  for (genvar i = 0; i < NUM_LOCKS; i++) begin : g_lock
    sync_debounce #(
      .DEBOUNCE_CYCLES(0),
      .INIT           (1'b0)
    ) u_sync (
      .clk    (clk),
      .reset_n(reset_n_i),
      .raw    (locked_i[i]),
      .level  (lock_sync[i])
    );
  end

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    sync_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .INIT           (BTN_RELEASED)
    ) u_debounce (
      .clk    (clk),
      .reset_n(reset_n_i),
      .raw    (btn_i[i]),
      .level  (btn_level[i])
    );
  end

  assign btn_pressed = BTN_ACTIVE_LOW ? ~btn_level : btn_level;
  assign lock_lost   = ~&lock_sync;
  assign btn_fault   = |btn_pressed;
  assign fault       = lock_lost | btn_fault | sw_reset_i;

  rst_state_t    state, state_next;
  logic [HW-1:0] hold_cnt, hold_next;
  logic [SW-1:0] stage_cnt, stage_next;
  logic [IW-1:0] idx, idx_next;
  reset_cause_t  cause, cause_next;

  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      state     <= ST_ASSERT;
      hold_cnt  <= '0;
      stage_cnt <= '0;
      idx       <= '0;
      cause     <= CAUSE_POR;
    end else begin
      state     <= state_next;
      hold_cnt  <= hold_next;
      stage_cnt <= stage_next;
      idx       <= idx_next;
      cause     <= cause_next;
    end
  end

  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    stage_next = stage_cnt;
    idx_next   = idx;
    cause_next = cause;
    case (state)
      ST_ASSERT: begin
        if (fault) begin
          hold_next = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_next = ST_RELEASE;
          hold_next  = '0;
          stage_next = '0;
          idx_next   = '0;
        end else begin
          hold_next = hold_cnt + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (idx == IDX_LAST) begin
          state_next = ST_RUN;
        end else if (stage_cnt == STAGE_LAST) begin
          idx_next   = idx + 1'b1;
          stage_next = '0;
        end else begin
          stage_next = stage_cnt + 1'b1;
        end
      end
      ST_RUN: begin
      end
      default: state_next = ST_ASSERT;
    endcase
    // A fault outside ASSERT overrides any release step scheduled this cycle.
    if (state != ST_ASSERT && fault) begin
      state_next = ST_ASSERT;
      hold_next  = '0;
      stage_next = '0;
      idx_next   = '0;
      cause_next = lock_lost ? CAUSE_LOCK : (btn_fault ? CAUSE_BUTTON : CAUSE_SW);
    end
  end

  always_comb begin
    reset_o = '1;
    ready_o = 1'b0;
    case (state)
      ST_RELEASE: begin
        for (int i = 0; i < NUM_DOMAINS; i++) begin
          reset_o[i] = (IW'(i) > idx);
        end
      end
      ST_RUN: begin
        reset_o = '0;
        ready_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign cause_o = cause;
  assign state_o = state;

endmodule

// File: tb/tb_board_reset_seq.sv
// Randomised bench for board_reset_seq: a timing-level reference model pushes
// every expected output change into a queue; a monitor pops on each DUT change.
module tb_board_reset_seq;
  import board_pkg::*;

  localparam int NL    = 2;
  localparam int NB    = 1;
  localparam int ND    = 3;
  localparam int HOLD  = 16;
  localparam int STAGE = 4;
  localparam int DEB   = 8;
  localparam int W     = 22;

  logic          clk = 1'b0;
  logic          reset_n_i;
  logic [NL-1:0] locked_i;
  logic [NB-1:0] btn_i;
  logic          sw_reset_i;
  logic [ND-1:0] reset_o;
  logic          ready_o;
  reset_cause_t  cause_o;
  rst_state_t    state_o;

  always #5 clk = ~clk;

  board_reset_seq #(
    .NUM_LOCKS      (NL),
    .NUM_BTNS       (NB),
    .BTN_ACTIVE_LOW (1'b1),
    .NUM_DOMAINS    (ND),
    .HOLD_CYCLES    (HOLD),
    .STAGE_CYCLES   (STAGE),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk       (clk),
    .reset_n_i (reset_n_i),
    .locked_i  (locked_i),
    .btn_i     (btn_i),
    .sw_reset_i(sw_reset_i),
    .reset_o   (reset_o),
    .ready_o   (ready_o),
    .cause_o   (cause_o),
    .state_o   (state_o)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // Reference model: domains are described by time since release began,
  // domain i is out of reset once i*STAGE cycles have elapsed.
  bit            started = 1'b0;
  int            cyc = 0;
  bit            m_assert = 1'b1;
  int            m_clean = 0;
  int            m_rel = 0;
  logic [1:0]    m_cause = 2'd0;
  logic [NL-1:0] m_l1, m_l2;
  logic          m_b1, m_b2, m_deb;
  logic          m_hist[$];
  logic [5:0]    m_last = 'x;

  function automatic logic [ND-1:0] model_reset();
    logic [ND-1:0] r;
    for (int i = 0; i < ND; i++) r[i] = m_assert ? 1'b1 : (m_rel < i * STAGE);
    return r;
  endfunction

  function automatic logic model_ready();
    return !m_assert && (m_rel >= (ND - 1) * STAGE + 1);
  endfunction

  always @(posedge clk) begin : model
    logic lock_lost, btn_fault, fault, all_diff;
    logic [5:0] now;
    if (reset_n_i === 1'b0) started = 1'b1;
    if (started) begin
      cyc++;
      if (!reset_n_i) begin
        m_assert = 1'b1; m_clean = 0; m_rel = 0; m_cause = 2'd0;
        m_l1 = '0; m_l2 = '0; m_b1 = 1'b1; m_b2 = 1'b1; m_deb = 1'b1;
        m_hist = {};
        for (int i = 0; i < DEB; i++) m_hist.push_back(1'b1);
      end else begin
        lock_lost = (m_l2 != '1);
        btn_fault = (m_deb == 1'b0);
        fault     = lock_lost | btn_fault | sw_reset_i;
        if (m_assert) begin
          if (fault) m_clean = 0;
          else begin
            m_clean++;
            if (m_clean == HOLD) begin m_assert = 1'b0; m_rel = 0; end
          end
        end else if (fault) begin
          m_assert = 1'b1; m_clean = 0;
          m_cause = lock_lost ? 2'd1 : (btn_fault ? 2'd2 : 2'd3);
        end else if (m_rel < 1000) begin
          m_rel++;
        end
        // Debounced level flips once the last DEB synchronised samples all disagree.
        m_hist.push_back(m_b2);
        if (m_hist.size() > DEB) void'(m_hist.pop_front());
        all_diff = 1'b1;
        foreach (m_hist[i]) if (m_hist[i] == m_deb) all_diff = 1'b0;
        if (all_diff) m_deb = ~m_deb;
        m_l2 = m_l1; m_l1 = locked_i;
        m_b2 = m_b1; m_b1 = btn_i[0];
      end
      now = {model_reset(), model_ready(), m_cause};
      if (now !== m_last) exp_q.push_back({cyc[15:0], now});
      m_last = now;
    end
  end

  logic [5:0] mon_last = 'x;

  always @(negedge clk) begin : monitor
    logic [5:0]   now;
    logic [W-1:0] got, exp;
    if (started) begin
      now = {reset_o, ready_o, cause_o};
      if (now !== mon_last) begin
        got = {cyc[15:0], now};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_change cyc=%0d got reset=%b ready=%b cause=%0d, expected no change",
                   cyc, reset_o, ready_o, cause_o);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL out_change got cyc=%0d reset=%b ready=%b cause=%0d, expected cyc=%0d reset=%b ready=%b cause=%0d",
                     got[21:6], got[5:3], got[2], got[1:0], exp[21:6], exp[5:3], exp[2], exp[1:0]);
          end
        end
        mon_last = now;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ready(input string tag, input int budget);
    int k = 0;
    while (ready_o !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= budget) begin
      errors++;
      $display("FAIL %s ready_o=%b after %0d cycles, expected 1", tag, ready_o, budget);
    end
  endtask

  task automatic wait_release(input string tag, input int rel, input int budget);
    int k = 0;
    while (!(!m_assert && m_rel == rel) && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= budget) begin
      errors++;
      $display("FAIL %s release point %0d not reached in %0d cycles", tag, rel, budget);
    end
  endtask

  task automatic pulse_sw();
    sw_reset_i = 1'b1; tick(1); sw_reset_i = 1'b0;
  endtask

  task automatic press_btn(input int len);
    btn_i[0] = 1'b0; tick(len); btn_i[0] = 1'b1;
  endtask

  task automatic drop_lock(input int idx, input int len);
    locked_i[idx] = 1'b0; tick(len); locked_i[idx] = 1'b1;
  endtask

  initial begin
    reset_n_i = 1'b0; locked_i = '1; btn_i = '1; sw_reset_i = 1'b0;
    tick(2);
    reset_n_i = 1'b1;
    wait_ready("power_on", 80);
    tick($urandom_range(2, 10));

    drop_lock(1, 1);
    wait_ready("lock_loss", 80);
    tick(3);

    for (int i = 0; i < 4; i++) begin
      press_btn($urandom_range(1, 5));
      tick($urandom_range(1, 4));
    end
    tick(10);
    press_btn(8 + $urandom_range(0, 4));
    wait_ready("button", 120);
    tick(3);

    drop_lock(0, 1);
    wait_release("sw_mid", 2, 80);
    pulse_sw();
    wait_ready("sw_mid_release", 80);
    tick(3);

    locked_i[0] = 1'b0;
    tick(2);
    pulse_sw();
    locked_i[0] = 1'b1;
    tick($urandom_range(4, 10));
    pulse_sw();
    wait_ready("simultaneous", 80);

    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 3))
        0: drop_lock($urandom_range(0, NL - 1), $urandom_range(1, 3));
        1: pulse_sw();
        2: press_btn($urandom_range(1, 12));
        default: begin
          for (int j = 0; j < 3; j++) begin
            press_btn($urandom_range(1, 6));
            tick($urandom_range(1, 3));
          end
        end
      endcase
      tick($urandom_range(3, 40));
    end
    wait_ready("random", 150);

    drop_lock(1, 1);
    wait_release("mid_reset", 5, 80);
    reset_n_i = 1'b0;
    tick(1);
    reset_n_i = 1'b1;
    wait_ready("after_reset", 80);
    tick(5);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain pending=%0d, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
